// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the four-digit seven-segment status scanner:
//   - glyph codes used by the frame composer and the glyph ROM
//   - active-high segment patterns, bit 6 = segment a ... bit 0 = segment g
//   - counter widths sized for the largest legal divider values
//   - frame_glyph(): picks the glyph for one digit position of a frame
// -----------------------------------------------------------------------------
package display_pkg;

    // Prescaler must hold SCAN_DIV-1 up to 2^20-1; blink counter up to 1022.
    localparam int PRESCALE_W = 20;
    localparam int BLINK_W    = 10;

    typedef enum logic [3:0] {
        G_0     = 4'd0,
        G_1     = 4'd1,
        G_2     = 4'd2,
        G_3     = 4'd3,
        G_L     = 4'd4,
        G_S     = 4'd5,
        G_P     = 4'd6,
        G_R     = 4'd7,
        G_I     = 4'd8,
        G_D     = 4'd9,
        G_BLANK = 4'd10
    } glyph_e;

    // Lit segments, {a,b,c,d,e,f,g}. The ROM inverts them for the
    // active-low drivers.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_L     = 7'b0001110;
    localparam logic [6:0] SEG_S     = 7'b1011011;
    localparam logic [6:0] SEG_P     = 7'b1100111;
    localparam logic [6:0] SEG_R     = 7'b0000101;
    localparam logic [6:0] SEG_I     = 7'b0000110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Glyph for digit position idx (3 = leftmost) of a latched frame.
    function automatic glyph_e frame_glyph(
        input logic       page_irr,
        input logic [1:0] level,
        input logic       sprinkler,
        input logic [1:0] idx
    );
        glyph_e g;
        g = G_BLANK;
        if (page_irr) begin
            if (sprinkler) begin
                case (idx)
                    2'd3:    g = G_S;
                    2'd2:    g = G_P;
                    2'd1:    g = G_R;
                    default: g = G_I;
                endcase
            end else begin
                case (idx)
                    2'd3:    g = G_D;
                    2'd2:    g = G_R;
                    2'd1:    g = G_I;
                    default: g = G_P;
                endcase
            end
        end else if (idx == 2'd3) begin
            g = G_L;
        end else if (idx == 2'd0) begin
            case (level)
                2'd0:    g = G_0;
                2'd1:    g = G_1;
                2'd2:    g = G_2;
                default: g = G_3;
            endcase
        end
        return g;
    endfunction

endpackage

// File: rtl/glyph_rom.sv
// -----------------------------------------------------------------------------
// glyph_rom
// Purely combinational glyph-code to segment decoder.
// Ports:
//   glyph_i  [3:0] glyph code (display_pkg::glyph_e values)
//   seg_n_o  [6:0] active-low segments {a,b,c,d,e,f,g}
// Codes with no glyph assigned decode to all segments off.
// -----------------------------------------------------------------------------
module glyph_rom
    import display_pkg::*;
(
    input  logic [3:0] glyph_i,
    output logic [6:0] seg_n_o
);

    logic [6:0] seg_on;

    always_comb begin
        seg_on = SEG_BLANK;
        case (glyph_i)
            G_0:     seg_on = SEG_0;
            G_1:     seg_on = SEG_1;
            G_2:     seg_on = SEG_2;
            G_3:     seg_on = SEG_3;
            G_L:     seg_on = SEG_L;
            G_S:     seg_on = SEG_S;
            G_P:     seg_on = SEG_P;
            G_R:     seg_on = SEG_R;
            G_I:     seg_on = SEG_I;
            G_D:     seg_on = SEG_D;
            default: seg_on = SEG_BLANK;
        endcase
        seg_n_o = ~seg_on;
    end

endmodule

// File: rtl/display_scanner.sv
// -----------------------------------------------------------------------------
// display_scanner
// Multiplexes a four-digit, active-low seven-segment display showing either
// the water level page ("L  n") or the irrigation page ("SPrI"/"drIP"), with
// an optional blinking alarm indication.
// Parameters:
//   SCAN_DIV   clock cycles per digit slot (2 .. 2^20)
//   BLINK_DIV  scan ticks per alarm blink half-period (1 .. 1023)
// Ports:
//   clock                 system clock, rising edge
//   reset_n               asynchronous active-low reset
//   encoded_water [1:0]   water level 0..3
//   splinker_mode_on      1 = sprinkler, 0 = dripper
//   alarm                 alarm active
//   selector              0 = water page, 1 = irrigation page
//   segment_a..segment_g  active-low segment drives
//   display_0..display_3  active-low digit enables (display_3 leftmost)
//   displays_point        active-low decimal point
// -----------------------------------------------------------------------------
module display_scanner
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] encoded_water,
    input  logic       splinker_mode_on,
    input  logic       alarm,
    input  logic       selector,
    output logic       segment_a,
    output logic       segment_b,
    output logic       segment_c,
    output logic       segment_d,
    output logic       segment_e,
    output logic       segment_f,
    output logic       segment_g,
    output logic       display_0,
    output logic       display_1,
    output logic       display_2,
    output logic       display_3,
    output logic       displays_point
);

    // Reset: asserted asynchronously, released through two flops so all
    // state leaves reset on the same clean edge.
    logic [1:0] rst_sync_q;

    // Input synchronisers, packed {alarm, selector, encoded_water, mode}.
    logic [4:0] in_meta_q;
    logic [4:0] in_sync_q;

    logic [PRESCALE_W-1:0] presc_q;
    logic [PRESCALE_W-1:0] presc_d;
    logic                  tick;
    logic [1:0]            index_q;
    logic                  started_q;
    logic [BLINK_W-1:0]    blink_cnt_q;
    logic                  blink_phase_q;
    logic                  blink_wrap;

    // Frame latch: only updated when the index wraps 3 -> 0.
    logic       frame_alarm_q;
    logic       frame_page_q;
    logic [1:0] frame_level_q;
    logic       frame_mode_q;
    logic       frame_boundary;
    logic       alarm_d;

    logic       blank;
    glyph_e     glyph_cur;
    logic [6:0] seg_n;

    // Registered outputs.
    logic [6:0] seg_q;
    logic [3:0] en_q;
    logic       dp_q;

    always_comb begin
        tick           = (presc_q == PRESCALE_W'(SCAN_DIV - 1));
        presc_d        = tick ? '0 : presc_q + 1'b1;
        blink_wrap     = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        frame_boundary = tick && (index_q == 2'd3);
        alarm_d        = frame_boundary ? in_sync_q[4] : frame_alarm_q;
        // Dark until the first tick, and during the alarm's dark half-period.
        blank          = !started_q || (frame_alarm_q && blink_phase_q);
        glyph_cur      = frame_glyph(frame_page_q, frame_level_q, frame_mode_q, index_q);
    end

    glyph_rom u_glyph_rom (
        .glyph_i (glyph_cur),
        .seg_n_o (seg_n)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_meta_q     <= '0;
            in_sync_q     <= '0;
            presc_q       <= '0;
            index_q       <= 2'd0;
            started_q     <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            frame_alarm_q <= 1'b0;
            frame_page_q  <= 1'b0;
            frame_level_q <= 2'd0;
            frame_mode_q  <= 1'b0;
            seg_q         <= '1;
            en_q          <= '1;
            dp_q          <= 1'b1;
        end else if (rst_sync_q[1]) begin
            in_meta_q <= {alarm, selector, encoded_water, splinker_mode_on};
            in_sync_q <= in_meta_q;
            presc_q   <= presc_d;

            if (tick) begin
                index_q   <= index_q + 2'd1;
                started_q <= 1'b1;
            end

            if (frame_boundary) begin
                frame_alarm_q <= in_sync_q[4];
                frame_page_q  <= in_sync_q[3];
                frame_level_q <= in_sync_q[2:1];
                frame_mode_q  <= in_sync_q[0];
            end

            // The counter stays cleared on the boundary that raises the alarm,
            // so the first half-period is a full lit one; it clears at once
            // when the alarm drops.
            if (!frame_alarm_q || !alarm_d) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= 1'b0;
            end else if (tick) begin
                if (blink_wrap) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end

            // Outputs follow the index/phase updated by the previous tick edge.
            en_q  <= blank ? 4'hF : ~(4'b0001 << index_q);
            seg_q <= blank ? 7'h7F : seg_n;
            dp_q  <= !(frame_alarm_q && !blank && (index_q == 2'd0));
        end
    end

    assign segment_a      = seg_q[6];
    assign segment_b      = seg_q[5];
    assign segment_c      = seg_q[4];
    assign segment_d      = seg_q[3];
    assign segment_e      = seg_q[2];
    assign segment_f      = seg_q[1];
    assign segment_g      = seg_q[0];
    assign display_0      = en_q[0];
    assign display_1      = en_q[1];
    assign display_2      = en_q[2];
    assign display_3      = en_q[3];
    assign displays_point = dp_q;

endmodule

// File: tb/tb_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_display_scanner
// Directed bench for display_scanner with SCAN_DIV=4, BLINK_DIV=2. Expected
// digit slots are pushed to a scoreboard queue and popped as each slot
// appears on the outputs; every falling edge also checks that at most one
// digit enable is low.
// -----------------------------------------------------------------------------
module tb_display_scanner;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    // Active-low segment patterns {a..g}.
    localparam logic [6:0] N0  = 7'b0000001;
    localparam logic [6:0] N1  = 7'b1001111;
    localparam logic [6:0] N2  = 7'b0010010;
    localparam logic [6:0] N3  = 7'b0000110;
    localparam logic [6:0] GL  = 7'b1110001;
    localparam logic [6:0] GS  = 7'b0100100;
    localparam logic [6:0] GP  = 7'b0011000;
    localparam logic [6:0] GR  = 7'b1111010;
    localparam logic [6:0] GI  = 7'b1111001;
    localparam logic [6:0] GD  = 7'b1000010;
    localparam logic [6:0] BLK = 7'b1111111;

    typedef struct packed {
        logic [3:0] en;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic [1:0] encoded_water;
    logic       splinker_mode_on;
    logic       alarm;
    logic       selector;
    logic       segment_a, segment_b, segment_c, segment_d;
    logic       segment_e, segment_f, segment_g;
    logic       display_0, display_1, display_2, display_3;
    logic       displays_point;

    logic [6:0] seg;
    logic [3:0] en;
    assign seg = {segment_a, segment_b, segment_c, segment_d, segment_e, segment_f, segment_g};
    assign en  = {display_3, display_2, display_1, display_0};

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    // Content of the frame currently expected on the display.
    logic       f_page;
    logic [1:0] f_level;
    logic       f_mode;
    logic       f_alarm;

    display_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .encoded_water    (encoded_water),
        .splinker_mode_on (splinker_mode_on),
        .alarm            (alarm),
        .selector         (selector),
        .segment_a        (segment_a),
        .segment_b        (segment_b),
        .segment_c        (segment_c),
        .segment_d        (segment_d),
        .segment_e        (segment_e),
        .segment_f        (segment_f),
        .segment_g        (segment_g),
        .display_0        (display_0),
        .display_1        (display_1),
        .display_2        (display_2),
        .display_3        (display_3),
        .displays_point   (displays_point)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Advance to the next falling edge and confirm at most one enable is low.
    task automatic tick();
        @(negedge clock);
        check("onehot_en", 16'($countones(~en) <= 1), 16'd1);
    endtask

    task automatic check_all_high(input string tag);
        check({tag, "_seg"}, 16'(seg), 16'(BLK));
        check({tag, "_en"},  16'(en),  16'hF);
        check({tag, "_dp"},  16'(displays_point), 16'd1);
    endtask

    function automatic exp_t model(input logic page, input logic [1:0] level,
                                   input logic mode, input logic alm, input int idx);
        exp_t       e;
        logic [6:0] g;
        g = BLK;
        if (page) begin
            if (mode) begin
                case (idx)
                    3: g = GS;
                    2: g = GP;
                    1: g = GR;
                    default: g = GI;
                endcase
            end else begin
                case (idx)
                    3: g = GD;
                    2: g = GR;
                    1: g = GI;
                    default: g = GP;
                endcase
            end
        end else if (idx == 3) begin
            g = GL;
        end else if (idx == 0) begin
            case (level)
                2'd0: g = N0;
                2'd1: g = N1;
                2'd2: g = N2;
                default: g = N3;
            endcase
        end
        case (idx)
            0: e.en = 4'b1110;
            1: e.en = 4'b1101;
            2: e.en = 4'b1011;
            default: e.en = 4'b0111;
        endcase
        e.seg = g;
        e.dp  = !(alm && idx == 0);
        // With BLINK_DIV=2 the lit half covers slots 0,1 and the dark half 2,3.
        if (alm && idx >= 2) begin
            e.en  = 4'hF;
            e.seg = BLK;
            e.dp  = 1'b1;
        end
        return e;
    endfunction

    task automatic wait_check(input int n);
        exp_t e;
        repeat (n) tick();
        if (sb.size() == 0) begin
            check("sb_underflow", 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            $display("slot t=%0t en=%b seg=%b dp=%b (exp en=%b seg=%b dp=%b)",
                     $time, en, seg, displays_point, e.en, e.seg, e.dp);
            check("slot_en",  16'(en),  16'(e.en));
            check("slot_seg", 16'(seg), 16'(e.seg));
            check("slot_dp",  16'(displays_point), 16'(e.dp));
        end
    endtask

    task automatic slots(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            sb.push_back(model(f_page, f_level, f_mode, f_alarm, i));
            wait_check(SCAN_DIV);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        selector         = 1'b0;
        encoded_water    = 2'b10;
        splinker_mode_on = 1'b0;
        alarm            = 1'b0;
        f_page  = 1'b0;
        f_level = 2'd0;
        f_mode  = 1'b0;
        f_alarm = 1'b0;

        repeat (3) tick();
        check_all_high("reset");

        // Release; first tick SCAN_DIV cycles after internal release (2 sync flops).
        reset_n = 1'b1;
        repeat (SCAN_DIV + 2) tick();
        check("pre_first_tick_en", 16'(en), 16'hF);
        sb.push_back(model(f_page, f_level, f_mode, f_alarm, 1));
        wait_check(1);
        slots(2, 3);

        // Water page, level 2.
        f_level = 2'd2;
        slots(0, 1);
        selector = 1'b1;
        splinker_mode_on = 1'b1;
        slots(2, 3);

        // "SPrI", then mode toggled mid-frame.
        f_page = 1'b1;
        f_mode = 1'b1;
        slots(0, 1);
        splinker_mode_on = 1'b0;
        slots(2, 3);

        // "drIP", alarm raised mid-frame.
        f_mode = 1'b0;
        slots(0, 1);
        alarm = 1'b1;
        slots(2, 3);

        f_alarm = 1'b1;
        slots(0, 3);
        slots(0, 1);
        alarm = 1'b0;
        slots(2, 3);

        // Alarm gone: steady display, point high.
        f_alarm = 1'b0;
        slots(0, 1);
        selector = 1'b0;
        encoded_water = 2'b11;
        slots(2, 3);

        // Water level 3, with a 3-cycle selector pulse inside the frame.
        f_page  = 1'b0;
        f_level = 2'd3;
        slots(0, 0);
        selector = 1'b1;
        repeat (3) tick();
        selector = 1'b0;
        sb.push_back(model(f_page, f_level, f_mode, f_alarm, 1));
        wait_check(SCAN_DIV - 3);
        encoded_water = 2'b01;
        slots(2, 3);

        f_level = 2'd1;
        slots(0, 1);

        // Reset mid-frame: outputs must go high before the next edge.
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1 check_all_high("async_reset");
        f_level = 2'd0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (SCAN_DIV + 2) tick();
        check("recover_pre_tick_en", 16'(en), 16'hF);
        sb.push_back(model(f_page, f_level, f_mode, f_alarm, 1));
        wait_check(1);
        slots(2, 3);
        f_level = 2'd1;
        slots(0, 0);

        check("sb_empty", 16'(sb.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles per digit slot (legal range 2..2^20).
REQ-002 Parameter BLINK_DIV, default 250, scan ticks per alarm blink half-period (legal range 1..1023).
REQ-003 Port clock  in  1  single system clock, rising edge.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port encoded_water  in  2  water level code: 00 empty, 01 low, 10 mid, 11 high.
REQ-006 Port splinker_mode_on  in  1  1 = sprinkler mode, 0 = dripper mode.
REQ-007 Port alarm  in  1  alarm active.
REQ-008 Port selector  in  1  page select: 0 = water page, 1 = irrigation page.
REQ-009 Port segment_a..segment_g  out  1 each  segment drive, active-low.
REQ-010 Port display_0..display_3  out  1 each  digit enable, active-low; display_3 is leftmost.
REQ-011 Port displays_point  out  1  decimal point, active-low.

Function
REQ-012 The prescaler SHALL count 0..SCAN_DIV-1 and assert a one-cycle scan tick when it wraps to 0.
REQ-013 The 2-bit digit index SHALL advance 0->1->2->3->0 on each scan tick.
REQ-014 Exactly one display_n SHALL be low at any time after the first scan tick following reset, namely display_[index].
REQ-015 Segment and digit outputs SHALL be registered, changing one clock after the scan tick that changes the index.
REQ-016 selector, encoded_water and splinker_mode_on SHALL pass through a 2-flop synchroniser; alarm likewise.
REQ-017 Displayed content SHALL be captured into a frame latch only on the scan tick that moves index from 3 to 0, so a frame never mixes two pages or two levels.
REQ-018 Water page, digits 3..0: 'L', blank, blank, numeral 0/1/2/3 equal to the latched encoded_water value.
REQ-019 Irrigation page: "SPrI" when latched splinker_mode_on = 1, "drIP" when 0.
REQ-020 The blink counter SHALL count scan ticks 0..BLINK_DIV-1 and toggle blink_phase on wrap.
REQ-021 While latched alarm = 1, digit enables SHALL all be high (blank) whenever blink_phase = 1, and displays_point SHALL be low on digit 0 whenever the digits are lit.
REQ-022 While latched alarm = 0, displays_point SHALL be high, and blink_phase SHALL be held at 0 with the blink counter held at 0.
REQ-023 An alarm rising edge SHALL take effect at the next frame boundary and always start with a lit half-period.
REQ-024 A selector change mid-frame SHALL be ignored until the frame boundary; a change and a revert within one frame SHALL produce no visible change.
REQ-025 An unmapped glyph SHALL drive all segments high (blank).

Reset
REQ-026 reset_n low SHALL immediately force: all segments high, all digit enables high, displays_point high.
REQ-027 Reset SHALL clear prescaler, index, blink counter, blink_phase, synchronisers and frame latch (water page, level 00, no alarm).
REQ-028 Reset deassertion SHALL be synchronised internally; the first scan tick occurs SCAN_DIV cycles after deassertion.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no partial glyph remaining on the outputs.

Structure
REQ-030 Package display_pkg SHALL hold the glyph code enum (0-3, L, S, P, r, I, d, blank) and the 7-bit segment pattern constants.
REQ-031 Sub-module glyph_rom SHALL map glyph code to the active-low segment_a..g vector combinationally; all registers reside in display_scanner.

Verification (SCAN_DIV=4, BLINK_DIV=2)
REQ-032 Reset, selector=0, encoded_water=10 -> after the first frame boundary, digit 0 shows '2' and digit 3 shows 'L'; the enable rotates every 4 cycles.
REQ-033 selector=1, splinker_mode_on=1 -> "SPrI"; toggle splinker_mode_on to 0 mid-frame -> "drIP" from the next frame only.
REQ-034 alarm=1 -> lit for 2 scan ticks, blank for 2, repeating; point low on digit 0 while lit; alarm=0 -> steady display, point high.
REQ-035 selector pulse 1 for 3 cycles inside one frame -> no page change observed.
REQ-036 Assert reset_n mid-frame -> all outputs high asynchronously in the same cycle; on release, recovery occurs per REQ-028.
REQ-037 At every cycle, a checker SHALL confirm at most one display_n is low.
